ps2_kbd_rx: RTL

//  Parametrised PS/2 keyboard receiver, successor to the fixed 8-deep ps2_keyboard.

---
 rtl/ps2_kbd_rx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: oversampled frame checker, optional E0/F0 folding, FWFT event FIFO.
// Push lands one cycle after frame end; head is visible the cycle after that.
module ps2_kbd_rx #(
   parameter int ADDR_W      = 3,
   parameter bit RAW_MODE    = 1'b0,
   parameter int TIMEOUT_CYC = 5000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ps2_clk,
   input  logic              ps2_data,
   output logic [9:0]        data,
   output logic              data_valid,
   input  logic              data_ready,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              err_frame,
   input  logic              clr_err
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [2:0]       clk_sync;
   logic [2:0]       dat_sync;
   logic [10:0]      shreg;
   logic [10:0]      shreg_nxt;
   logic [3:0]       bit_cnt;
   logic [TMO_W-1:0] tmo;
   logic             fall;
   logic             frame_end;
   logic             frame_ok;
   logic             tmo_hit;
   logic             frame_err;
   logic             code_vld;
   logic [7:0]       code;
   logic             ext_pend;
   logic             brk_pend;
   logic             push;
   logic [9:0]       push_dat;

   logic [9:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] rd_nxt;
   logic [ADDR_W:0]   count_nxt;
   logic              pop;
   logic              full;
   logic              wr_en;

   // Data is taken from the older sync stage: it was stable while ps2_clk was still high.
   assign fall      = (clk_sync[2:1] == 2'b10);
   assign shreg_nxt = {dat_sync[2], shreg[10:1]};
   assign frame_end = fall && (bit_cnt == 4'd10);
   assign frame_ok  = !shreg_nxt[0] && shreg_nxt[10] && (^shreg_nxt[9:1]);
   assign tmo_hit   = (bit_cnt != 4'd0) && !fall && (tmo == TMO_W'(TIMEOUT_CYC - 1));
   assign frame_err = (frame_end && !frame_ok) || tmo_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync <= 3'b111;
         dat_sync <= 3'b111;
         shreg    <= '0;
         bit_cnt  <= '0;
         tmo      <= '0;
         code_vld <= 1'b0;
         code     <= '0;
      end else begin
         clk_sync <= {clk_sync[1:0], ps2_clk};
         dat_sync <= {dat_sync[1:0], ps2_data};
         code_vld <= frame_end && frame_ok;
         if (frame_end)
            code <= shreg_nxt[8:1];
         if (fall) begin
            shreg   <= shreg_nxt;
            bit_cnt <= frame_end ? 4'd0 : bit_cnt + 4'd1;
            tmo     <= '0;
         end else if (bit_cnt == 4'd0) begin
            tmo <= '0;
         end else if (tmo_hit) begin
            bit_cnt <= '0;
            tmo     <= '0;
         end else begin
            tmo <= tmo + TMO_W'(1);
         end
      end
   end

   always_comb begin
      push     = 1'b0;
      push_dat = {ext_pend, brk_pend, code};
      if (code_vld) begin
         if (RAW_MODE) begin
            push     = 1'b1;
            push_dat = {2'b00, code};
         end else if (code != 8'hE0 && code != 8'hF0) begin
            push = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
      end else if (frame_err) begin
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
      end else if (code_vld && !RAW_MODE) begin
         if (code == 8'hE0)
            ext_pend <= 1'b1;
         else if (code == 8'hF0)
            brk_pend <= 1'b1;
         else begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
         end
      end
   end

   assign data_valid = (count != '0);
   assign pop        = data_valid && data_ready;
   assign full       = (count == (ADDR_W+1)'(DEPTH));
   assign wr_en      = push && (!full || pop);
   assign rd_nxt     = rd_ptr + ADDR_W'(pop);
   assign count_nxt  = count + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(pop);

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= push_dat;
   end

   // data is a register so it can hold its last value once the FIFO drains.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         data      <= '0;
         overflow  <= 1'b0;
         err_frame <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + ADDR_W'(1);
         rd_ptr <= rd_nxt;
         count  <= count_nxt;
         if (count_nxt != '0)
            data <= (wr_en && (wr_ptr == rd_nxt)) ? push_dat : mem[rd_nxt];
         if (push && full && !pop)
            overflow <= 1'b1;
         else if (clr_err)
            overflow <= 1'b0;
         if (frame_err)
            err_frame <= 1'b1;
         else if (clr_err)
            err_frame <= 1'b0;
      end
   end

endmodule
